// File: rtl/wb_master_initiator_if.sv
// Wishbone classic-cycle bus between the initiator (master) and the
// user-project address decoder (slave). Signal names keep the master's
// point of view (_o driven by the master, _i driven by the slave).
interface wb_master_initiator_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );
endinterface

// File: rtl/wb_master_initiator.sv
// Single-outstanding Wishbone classic-cycle initiator.
// Command and response streams use valid/ready: a transfer happens on a
// rising clock edge where valid and ready are both high; valid, once raised,
// is held with its payload stable until that edge.
// A watchdog ends any bus cycle not acknowledged within TIMEOUT strobe
// cycles and reports it as rsp_err=1.
module wb_master_initiator #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    wb_master_initiator_if.master wbm,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic             cmd_fire;
    logic             bus_ack;
    logic             bus_timeout;

    // Every control output is a pure decode of the state register, so no
    // input reaches an output combinationally.
    assign cmd_ready     = (state == S_IDLE);
    assign rsp_valid     = (state == S_RESP);
    assign busy          = (state != S_IDLE);
    assign wbm.wbm_cyc_o = (state == S_BUS);
    assign wbm.wbm_stb_o = (state == S_BUS);
    assign state_dbg     = state;

    // State register; reset aborts any cycle in flight without a response.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an ack on the final watchdog edge wins over timeout.
    always_comb begin
        state_next  = state;
        cmd_fire    = 1'b0;
        bus_ack     = 1'b0;
        bus_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_fire   = 1'b1;
                    state_next = S_BUS;
                end
            end
            S_BUS: begin
                if (wbm.wbm_ack_i) begin
                    bus_ack    = 1'b1;
                    state_next = S_RESP;
                end else if (timer == TIMER_LAST) begin
                    bus_timeout = 1'b1;
                    state_next  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Watchdog: cleared on command accept, counts strobe cycles without ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timer <= '0;
        end else if (cmd_fire) begin
            timer <= '0;
        end else if (state == S_BUS && !wbm.wbm_ack_i && timer != TIMER_LAST) begin
            timer <= timer + 1'b1;
        end
    end

    // Bus request fields: captured on accept, held after the cycle ends.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_sel_o <= 4'h0;
            wbm.wbm_adr_o <= 32'h0;
            wbm.wbm_dat_o <= 32'h0;
        end else if (cmd_fire) begin
            wbm.wbm_we_o  <= cmd_we;
            wbm.wbm_sel_o <= cmd_sel;
            wbm.wbm_adr_o <= cmd_adr;
            wbm.wbm_dat_o <= cmd_dat;
        end
    end

    // Response fields: written when the bus cycle ends, held through RESP.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rsp_dat <= 32'h0;
            rsp_err <= 1'b0;
        end else if (bus_ack) begin
            rsp_dat <= wbm.wbm_we_o ? 32'h0 : wbm.wbm_dat_i;
            rsp_err <= 1'b0;
        end else if (bus_timeout) begin
            rsp_dat <= 32'h0;
            rsp_err <= 1'b1;
        end
    end

endmodule
